// File: rtl/axi4_lite_slv_reg_file_pkg.sv
// Shared types and helpers for the AXI4-Lite register file: response codes, FSM states, byte merge.
// No logic of its own; used by both the top and the write controller.
package axi4_lite_reg_file_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi4_resp_t;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  // Sized for the widest supported bus; callers zero-extend in and truncate out.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_val,
    input logic [MAX_DATA_W-1:0] wdata,
    input logic [MAX_STRB_W-1:0] wstrb
  );
    logic [MAX_DATA_W-1:0] res;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      res[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_slv_reg_file_if.sv
// AXI4-Lite bundle with master and slave views.
// Pure wiring; handshakes follow standard valid/ready rules.
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
);
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport slv_port (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport mst_port (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_slv_reg_file_wr_ctrl.sv
// Write engine: latches AW/W in any order, commits on the edge both are held, bvalid 1 cycle later.
// One write outstanding; AW/W stall until bready; AXI4_LITE_REG_FILE_PROT_CHECK_EN enables prot check.
module axi4_lite_reg_file_wr_ctrl
  import axi4_lite_reg_file_pkg::*;
#(
  parameter int                  ADDR_BIT_WIDTH = 32,
  parameter int                  DATA_BIT_WIDTH = 32,
  parameter int                  NUM_REGS       = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK        = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  axi4_lite_if.slv_port               s_if,
  output logic                        wr_en,
  output logic [ADDR_BIT_WIDTH-1:0]   wr_idx,
  output logic [DATA_BIT_WIDTH-1:0]   wr_data,
  output logic [DATA_BIT_WIDTH/8-1:0] wr_strb
);

  localparam int OFFS_W = $clog2(DATA_BIT_WIDTH / 8);

  wr_state_t                   wr_state_q, wr_state_d;
  logic                        aw_vld_q, aw_vld_d;
  logic                        w_vld_q, w_vld_d;
  logic [ADDR_BIT_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_BIT_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb_q, wstrb_d;
  axi4_resp_t                  bresp_q, bresp_d;
`ifdef AXI4_LITE_REG_FILE_PROT_CHECK_EN
  logic [2:0]                  awprot_q, awprot_d;
  logic [2:0]                  prot_cur;
`endif

  logic                        aw_hs, w_hs, ro_hit;
  logic [ADDR_BIT_WIDTH-1:0]   addr_cur;
  axi4_resp_t                  resp_cur;

  assign s_if.awready = (wr_state_q == WR_IDLE) && !aw_vld_q;
  assign s_if.wready  = (wr_state_q == WR_IDLE) && !w_vld_q;
  assign s_if.bvalid  = (wr_state_q == WR_RESP);
  assign s_if.bresp   = bresp_q;

  assign aw_hs = s_if.awvalid && s_if.awready;
  assign w_hs  = s_if.wvalid && s_if.wready;

  // Already-latched beats win; otherwise the beat arriving this cycle is used.
  always_comb begin
    addr_cur = aw_vld_q ? awaddr_q : s_if.awaddr;
    wr_data  = w_vld_q ? wdata_q : s_if.wdata;
    wr_strb  = w_vld_q ? wstrb_q : s_if.wstrb;
`ifdef AXI4_LITE_REG_FILE_PROT_CHECK_EN
    prot_cur = aw_vld_q ? awprot_q : s_if.awprot;
`endif
    wr_idx   = addr_cur >> OFFS_W;
    ro_hit   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == ADDR_BIT_WIDTH'(i)) ro_hit = RO_MASK[i];
    end
    if (wr_idx >= ADDR_BIT_WIDTH'(NUM_REGS)) resp_cur = RESP_DECERR;
`ifdef AXI4_LITE_REG_FILE_PROT_CHECK_EN
    else if (!prot_cur[0]) resp_cur = RESP_SLVERR;
`endif
    else if (ro_hit) resp_cur = RESP_SLVERR;
    else resp_cur = RESP_OKAY;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_vld_d   = aw_vld_q;
    w_vld_d    = w_vld_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_en      = 1'b0;
`ifdef AXI4_LITE_REG_FILE_PROT_CHECK_EN
    awprot_d   = awprot_q;
`endif
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_vld_d = 1'b1;
          awaddr_d = s_if.awaddr;
`ifdef AXI4_LITE_REG_FILE_PROT_CHECK_EN
          awprot_d = s_if.awprot;
`endif
        end
        if (w_hs) begin
          w_vld_d = 1'b1;
          wdata_d = s_if.wdata;
          wstrb_d = s_if.wstrb;
        end
        if ((aw_vld_q || aw_hs) && (w_vld_q || w_hs)) begin
          wr_state_d = WR_RESP;
          bresp_d    = resp_cur;
          wr_en      = (resp_cur == RESP_OKAY);
          aw_vld_d   = 1'b0;
          w_vld_d    = 1'b0;
        end
      end
      WR_RESP: begin
        if (s_if.bready) wr_state_d = WR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      aw_vld_q   <= 1'b0;
      w_vld_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
`ifdef AXI4_LITE_REG_FILE_PROT_CHECK_EN
      awprot_q   <= '0;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      aw_vld_q   <= aw_vld_d;
      w_vld_q    <= w_vld_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
`ifdef AXI4_LITE_REG_FILE_PROT_CHECK_EN
      awprot_q   <= awprot_d;
`endif
    end
  end

endmodule

// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite register file: RW/RO registers, write engine in wr_ctrl, read engine here; B and R 1 cycle after handshake.
// One read and one write outstanding; R held until rready; AXI4_LITE_REG_FILE_PROT_CHECK_EN enables prot check.
module axi4_lite_slv_reg_file
  import axi4_lite_reg_file_pkg::*;
#(
  parameter int                        ADDR_BIT_WIDTH = 32,
  parameter int                        DATA_BIT_WIDTH = 32,
  parameter int                        NUM_REGS       = 16,
  parameter logic [NUM_REGS-1:0]       RO_MASK        = '0,
  parameter logic [DATA_BIT_WIDTH-1:0] RST_VAL        = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  axi4_lite_if.slv_port                      s_if,
  output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] ctrl_out,
  input  logic [NUM_REGS*DATA_BIT_WIDTH-1:0] sts_in,
  output logic [NUM_REGS-1:0]                wr_pulse
);

  localparam int OFFS_W = $clog2(DATA_BIT_WIDTH / 8);

  logic [NUM_REGS-1:0][DATA_BIT_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [NUM_REGS-1:0]                     wr_pulse_q, wr_pulse_d;
  rd_state_t                               rd_state_q, rd_state_d;
  logic [DATA_BIT_WIDTH-1:0]               rdata_q, rdata_d;
  axi4_resp_t                              rresp_q, rresp_d;

  logic                        wr_en;
  logic [ADDR_BIT_WIDTH-1:0]   wr_idx;
  logic [DATA_BIT_WIDTH-1:0]   wr_data;
  logic [DATA_BIT_WIDTH/8-1:0] wr_strb;
  logic [ADDR_BIT_WIDTH-1:0]   rd_idx;
  logic [DATA_BIT_WIDTH-1:0]   rd_val;

  axi4_lite_reg_file_wr_ctrl #(
    .ADDR_BIT_WIDTH(ADDR_BIT_WIDTH),
    .DATA_BIT_WIDTH(DATA_BIT_WIDTH),
    .NUM_REGS      (NUM_REGS),
    .RO_MASK       (RO_MASK)
  ) u_wr_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_if   (s_if),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_data(wr_data),
    .wr_strb(wr_strb)
  );

  assign ctrl_out     = ctrl_q;
  assign wr_pulse     = wr_pulse_q;
  assign s_if.arready = (rd_state_q == RD_IDLE);
  assign s_if.rvalid  = (rd_state_q == RD_DATA);
  assign s_if.rdata   = rdata_q;
  assign s_if.rresp   = rresp_q;

  always_comb begin
    ctrl_d     = ctrl_q;
    wr_pulse_d = '0;
    if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == ADDR_BIT_WIDTH'(i)) begin
          ctrl_d[i]     = DATA_BIT_WIDTH'(byte_merge(MAX_DATA_W'(ctrl_q[i]),
                                                     MAX_DATA_W'(wr_data),
                                                     MAX_STRB_W'(wr_strb)));
          wr_pulse_d[i] = 1'b1;
        end
      end
    end
  end

  // rd_val samples ctrl_q, so a read landing on a commit edge sees the pre-write value.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_idx     = s_if.araddr >> OFFS_W;
    rd_val     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == ADDR_BIT_WIDTH'(i)) begin
        rd_val = RO_MASK[i] ? sts_in[i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] : ctrl_q[i];
      end
    end
    case (rd_state_q)
      RD_IDLE: begin
        if (s_if.arvalid) begin
          rd_state_d = RD_DATA;
          if (rd_idx >= ADDR_BIT_WIDTH'(NUM_REGS)) begin
            rdata_d = '0;
            rresp_d = RESP_DECERR;
          end
`ifdef AXI4_LITE_REG_FILE_PROT_CHECK_EN
          else if (!s_if.arprot[0]) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
`endif
          else begin
            rdata_d = rd_val;
            rresp_d = RESP_OKAY;
          end
        end
      end
      RD_DATA: begin
        if (s_if.rready) rd_state_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= {NUM_REGS{RST_VAL}};
      wr_pulse_q <= '0;
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      ctrl_q     <= ctrl_d;
      wr_pulse_q <= wr_pulse_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// Directed bench for axi4_lite_slv_reg_file: 4 regs, reg 3 read-only, non-zero reset value.
// AXI4_LITE_REG_FILE_PROT_CHECK_EN adds the unprivileged-write case.
module tb_axi4_lite_slv_reg_file;

  localparam logic [31:0] RST = 32'hC0DE_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] ctrl_out;
  logic [127:0] sts_in;
  logic [3:0]   wr_pulse;
  logic [2:0]   prot_val = 3'b001;
  int           n_tests = 0;
  int           n_fail = 0;
  int           pulse_cnt [4];

  always #5 clk = ~clk;

  axi4_lite_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) s_if ();

  axi4_lite_slv_reg_file #(
    .ADDR_BIT_WIDTH(32),
    .DATA_BIT_WIDTH(32),
    .NUM_REGS      (4),
    .RO_MASK       (4'b1000),
    .RST_VAL       (RST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_if    (s_if),
    .ctrl_out(ctrl_out),
    .sts_in  (sts_in),
    .wr_pulse(wr_pulse)
  );

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (wr_pulse[i]) pulse_cnt[i]++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_txn(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int n = 0;
    s_if.awaddr  = addr;
    s_if.awprot  = prot_val;
    s_if.wdata   = data;
    s_if.wstrb   = strb;
    s_if.awvalid = 1'b1;
    s_if.wvalid  = 1'b1;
    s_if.bready  = 1'b1;
    while (!(aw_done && w_done) && n < 16) begin
      if (s_if.awvalid && s_if.awready) aw_done = 1'b1;
      if (s_if.wvalid && s_if.wready) w_done = 1'b1;
      tick();
      if (aw_done) s_if.awvalid = 1'b0;
      if (w_done) s_if.wvalid = 1'b0;
      n++;
    end
    s_if.awvalid = 1'b0;
    s_if.wvalid  = 1'b0;
    n = 0;
    while (!s_if.bvalid && n < 16) begin
      tick();
      n++;
    end
    resp = s_if.bresp;
    if (!s_if.bvalid) check("wr_b_timeout", s_if.bvalid, 1);
    tick();
    s_if.bready = 1'b0;
  endtask

  task automatic rd_txn(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    s_if.araddr  = addr;
    s_if.arprot  = prot_val;
    s_if.arvalid = 1'b1;
    s_if.rready  = 1'b1;
    while (!s_if.arready && n < 16) begin
      tick();
      n++;
    end
    if (!s_if.arready) check("rd_ar_timeout", s_if.arready, 1);
    tick();
    s_if.arvalid = 1'b0;
    n = 0;
    while (!s_if.rvalid && n < 16) begin
      tick();
      n++;
    end
    data = s_if.rdata;
    resp = s_if.rresp;
    if (!s_if.rvalid) check("rd_r_timeout", s_if.rvalid, 1);
    tick();
    s_if.rready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          held;
    int          pt;

    s_if.awaddr = '0; s_if.awprot = '0; s_if.awvalid = 1'b0;
    s_if.wdata = '0;  s_if.wstrb = '0;  s_if.wvalid = 1'b0;
    s_if.bready = 1'b0;
    s_if.araddr = '0; s_if.arprot = '0; s_if.arvalid = 1'b0;
    s_if.rready = 1'b0;
    sts_in = '0;

    #12;
    check("rst_ready", {s_if.awready, s_if.wready, s_if.arready}, 3'b111);
    check("rst_valid", {s_if.bvalid, s_if.rvalid}, 2'b00);
    check("rst_resp", {s_if.bresp, s_if.rresp}, 4'b0000);
    check("rst_rdata", s_if.rdata, 0);
    check("rst_ctrl", ctrl_out, {4{RST}});
    check("rst_pulse", wr_pulse, 4'b0000);
    #5 rst_n = 1'b1;
    tick();

    // 1: AW and W together
    s_if.awaddr = 32'h4; s_if.awprot = prot_val;
    s_if.wdata = 32'hDEADBEEF; s_if.wstrb = 4'hF;
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1; s_if.bready = 1'b0;
    tick();
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    check("t1_bvalid", s_if.bvalid, 1);
    check("t1_bresp", s_if.bresp, 2'b00);
    check("t1_pulse", wr_pulse, 4'b0010);
    s_if.bready = 1'b1;
    tick();
    s_if.bready = 1'b0;
    check("t1_after_b", {s_if.bvalid, s_if.awready, s_if.wready, wr_pulse}, 7'b0110000);
    check("t1_pulse_once", pulse_cnt[1], 1);
    rd_txn(32'h4, d, r);
    check("t1_rdata", d, 32'hDEADBEEF);
    check("t1_rresp", r, 2'b00);

    // 2: W three cycles ahead of AW, bready held off
    s_if.wdata = 32'h000000AA; s_if.wstrb = 4'h1; s_if.wvalid = 1'b1;
    tick();
    s_if.wvalid = 1'b0;
    check("t2_w_latched", {s_if.awready, s_if.wready, s_if.bvalid}, 3'b100);
    tick();
    tick();
    s_if.awaddr = 32'h0; s_if.awvalid = 1'b1; s_if.bready = 1'b0;
    tick();
    s_if.awvalid = 1'b0;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (s_if.bvalid && s_if.bresp == 2'b00) held++;
      tick();
    end
    check("t2_bvalid_held", held, 5);
    s_if.bready = 1'b1;
    tick();
    s_if.bready = 1'b0;
    check("t2_b_done", s_if.bvalid, 0);
    check("t2_reg0", ctrl_out[31:0], 32'hC0DE00AA);

    // 3: read-only register
    sts_in[127:96] = 32'h12345678;
    wr_txn(32'hC, 32'hFFFFFFFF, 4'hF, r);
    check("t3_bresp", r, 2'b10);
    check("t3_ctrl3", ctrl_out[127:96], RST);
    check("t3_no_pulse", pulse_cnt[3], 0);
    rd_txn(32'hC, d, r);
    check("t3_rdata", d, 32'h12345678);
    check("t3_rresp", r, 2'b00);

    // 4: out of range
    pt = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
    wr_txn(32'h10, 32'h5A5A5A5A, 4'hF, r);
    check("t4_bresp", r, 2'b11);
    check("t4_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], pt);
    check("t4_ctrl", ctrl_out, {RST, RST, 32'hDEADBEEF, 32'hC0DE00AA});
    rd_txn(32'h10, d, r);
    check("t4_rdata", d, 0);
    check("t4_rresp", r, 2'b11);

    // 5: read on the commit edge of a write to the same register
    wr_txn(32'h8, 32'h11, 4'hF, r);
    check("t5_pre_bresp", r, 2'b00);
    s_if.awaddr = 32'h8; s_if.wdata = 32'h55; s_if.wstrb = 4'hF;
    s_if.araddr = 32'h8; s_if.arprot = prot_val; s_if.awprot = prot_val;
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1; s_if.arvalid = 1'b1;
    s_if.bready = 1'b1; s_if.rready = 1'b1;
    tick();
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
    check("t5_both_valid", {s_if.bvalid, s_if.rvalid}, 2'b11);
    check("t5_old_rdata", s_if.rdata, 32'h11);
    tick();
    s_if.bready = 1'b0; s_if.rready = 1'b0;
    rd_txn(32'h8, d, r);
    check("t5_new_rdata", d, 32'h55);

    // 6: reset while both engines hold responses
    s_if.awaddr = 32'h4; s_if.wdata = 32'h77; s_if.wstrb = 4'hF;
    s_if.araddr = 32'h4;
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1; s_if.arvalid = 1'b1;
    s_if.bready = 1'b0; s_if.rready = 1'b0;
    tick();
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
    check("t6_pending", {s_if.bvalid, s_if.rvalid}, 2'b11);
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {s_if.bvalid, s_if.rvalid}, 2'b00);
    check("t6_rst_ctrl", ctrl_out, {4{RST}});
    #3 rst_n = 1'b1;
    tick();
    check("t6_ready", {s_if.awready, s_if.wready, s_if.arready}, 3'b111);
    wr_txn(32'h4, 32'h0BADF00D, 4'hF, r);
    check("t6_bresp", r, 2'b00);
    rd_txn(32'h4, d, r);
    check("t6_rdata", d, 32'h0BADF00D);

`ifdef AXI4_LITE_REG_FILE_PROT_CHECK_EN
    prot_val = 3'b000;
    wr_txn(32'h0, 32'h99999999, 4'hF, r);
    check("prot_bresp", r, 2'b10);
    check("prot_reg0", ctrl_out[31:0], RST);
    prot_val = 3'b001;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
